// File: rtl/ow_master_ctrl.sv
// ow_master_ctrl: 1-Wire bus master sequencer.
// Executes one command at a time: a reset/presence cycle, an 8-bit LSB-first
// write, or a 64-slot ROM read. It reports completion with a one-cycle
// rsp_valid pulse. All outputs are registered. Each one is computed from the
// next-state values, so it lines up with the state it belongs to.
module ow_master_ctrl #(
  parameter int T_SLOT   = 61,
  parameter int T_LOW1   = 6,
  parameter int T_LOW0   = 60,
  parameter int T_SAMPLE = 30,
  parameter int T_RSTL   = 480,
  parameter int T_RSTH   = 480,
  parameter int T_PRES   = 70
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_data,
  output logic        cmd_ready,
  input  logic        bus_in,
  output logic        bus_drive_low,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic        presence,
  output logic [63:0] rom_data
);

  localparam int T_MAX_A = (T_RSTL > T_RSTH) ? T_RSTL : T_RSTH;
  localparam int T_MAX   = (T_MAX_A > T_SLOT) ? T_MAX_A : T_SLOT;
  localparam int CNT_W   = $clog2(T_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(T_SLOT - 1);
  localparam logic [CNT_W-1:0] RSTL_LAST = CNT_W'(T_RSTL - 1);
  localparam logic [CNT_W-1:0] RSTH_LAST = CNT_W'(T_RSTH - 1);
  localparam logic [CNT_W-1:0] LOW1_LEN  = CNT_W'(T_LOW1);
  localparam logic [CNT_W-1:0] LOW0_LEN  = CNT_W'(T_LOW0);
  localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(T_SAMPLE);
  localparam logic [CNT_W-1:0] PRES_AT   = CNT_W'(T_PRES);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RST_LOW  = 3'd1;
  localparam logic [2:0] S_RST_WAIT = 3'd2;
  localparam logic [2:0] S_WR_SLOT  = 3'd3;
  localparam logic [2:0] S_RD_SLOT  = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_ILL   = 2'b11;

  localparam logic [5:0] WR_LAST_BIT = 6'd7;
  localparam logic [5:0] RD_LAST_BIT = 6'd63;

  logic [2:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [5:0]       bit_r;
  logic [1:0]       op_r;
  logic [7:0]       data_r;
  logic [63:0]      shift_r;
  logic             presence_tmp_r;

  logic [2:0]       next_state_s;
  logic [CNT_W-1:0] next_cnt_s;
  logic [5:0]       next_bit_s;
  logic [1:0]       next_op_s;
  logic [7:0]       next_data_s;
  logic             next_drive_s;

  // Next-state, slot counter and bit index sequencing.
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = cnt_r;
    next_bit_s   = bit_r;
    next_op_s    = op_r;
    next_data_s  = data_r;
    case (state_r)
      S_IDLE: begin
        if (cmd_valid) begin
          next_op_s   = cmd_op;
          next_data_s = cmd_data;
          next_cnt_s  = CNT_ZERO;
          next_bit_s  = 6'd0;
          case (cmd_op)
            OP_RESET: next_state_s = S_RST_LOW;
            OP_WRITE: next_state_s = S_WR_SLOT;
            OP_READ:  next_state_s = S_RD_SLOT;
            default:  next_state_s = S_DONE;
          endcase
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_RST_LOW: begin
        if (cnt_r == RSTL_LAST) begin
          next_state_s = S_RST_WAIT;
          next_cnt_s   = CNT_ZERO;
        end else begin
          next_cnt_s = cnt_r + CNT_ONE;
        end
      end
      S_RST_WAIT: begin
        if (cnt_r == RSTH_LAST) begin
          next_state_s = S_DONE;
          next_cnt_s   = CNT_ZERO;
        end else begin
          next_cnt_s = cnt_r + CNT_ONE;
        end
      end
      S_WR_SLOT, S_RD_SLOT: begin
        if (cnt_r == SLOT_LAST) begin
          next_cnt_s = CNT_ZERO;
          if (bit_r == ((state_r == S_WR_SLOT) ? WR_LAST_BIT : RD_LAST_BIT)) begin
            next_state_s = S_DONE;
            next_bit_s   = 6'd0;
          end else begin
            next_bit_s = bit_r + 6'd1;
          end
        end else begin
          next_cnt_s = cnt_r + CNT_ONE;
        end
      end
      S_DONE: begin
        next_state_s = S_IDLE;
        next_cnt_s   = CNT_ZERO;
      end
      default: begin
        next_state_s = S_IDLE;
        next_cnt_s   = CNT_ZERO;
        next_bit_s   = 6'd0;
      end
    endcase
  end

  // Bus drive level for the upcoming cycle, from the upcoming state and position.
  always_comb begin
    next_drive_s = 1'b0;
    case (next_state_s)
      S_RST_LOW: next_drive_s = 1'b1;
      S_WR_SLOT: begin
        if (next_data_s[next_bit_s[2:0]]) begin
          next_drive_s = (next_cnt_s < LOW1_LEN);
        end else begin
          next_drive_s = (next_cnt_s < LOW0_LEN);
        end
      end
      S_RD_SLOT: next_drive_s = (next_cnt_s < LOW1_LEN);
      default:   next_drive_s = 1'b0;
    endcase
  end

  // Control state and registered handshake/bus outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= S_IDLE;
      cnt_r         <= CNT_ZERO;
      bit_r         <= 6'd0;
      op_r          <= OP_RESET;
      data_r        <= 8'd0;
      bus_drive_low <= 1'b0;
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_err       <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      cnt_r         <= next_cnt_s;
      bit_r         <= next_bit_s;
      op_r          <= next_op_s;
      data_r        <= next_data_s;
      bus_drive_low <= next_drive_s;
      cmd_ready     <= (next_state_s == S_IDLE);
      rsp_valid     <= (next_state_s == S_DONE);
      rsp_err       <= (next_state_s == S_DONE) && (next_op_s == OP_ILL);
    end
  end

  // Sampling of the line and publication of results when an op completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r        <= 64'd0;
      presence_tmp_r <= 1'b0;
      presence       <= 1'b0;
      rom_data       <= 64'd0;
    end else begin
      if ((state_r == S_RST_WAIT) && (cnt_r == PRES_AT)) begin
        presence_tmp_r <= ~bus_in;
      end
      if ((state_r == S_RD_SLOT) && (cnt_r == SAMPLE_AT)) begin
        shift_r[bit_r] <= bus_in;
      end
      if ((state_r == S_RST_WAIT) && (next_state_s == S_DONE)) begin
        presence <= presence_tmp_r;
      end
      if ((state_r == S_RD_SLOT) && (next_state_s == S_DONE)) begin
        rom_data <= shift_r;
      end
    end
  end

endmodule

// File: tb/tb_ow_master_ctrl.sv
// tb_ow_master_ctrl: table-driven, hand-written and randomized checks of the
// 1-Wire master against a timing model derived from slot arithmetic.
module tb_ow_master_ctrl;

  localparam int T_SLOT = 61;
  localparam int T_LOW1 = 6;
  localparam int T_LOW0 = 60;
  localparam int T_RSTL = 480;
  localparam int T_RSTH = 480;
  localparam int T_PRES = 70;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic        cmd_ready;
  logic        bus_in;
  logic        bus_drive_low;
  logic        rsp_valid;
  logic        rsp_err;
  logic        presence;
  logic [63:0] rom_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] m_rom;
  logic        m_pres;

  ow_master_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_ready(cmd_ready), .bus_in(bus_in),
    .bus_drive_low(bus_drive_low), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .presence(presence), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  data;
    logic [63:0] rom_in;
    int          pres_lo;
    int          pres_hi;
    bit          hold_busy;
    int          exp_lat;
    bit          exp_err;
    bit          exp_pres;
    logic [63:0] exp_rom;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [7:0] data,
                              input logic [63:0] rom_in, input int lo, input int hi,
                              input bit hold, input int lat, input bit err,
                              input bit pres, input logic [63:0] rom);
    vec_t v;
    v.op = op; v.data = data; v.rom_in = rom_in; v.pres_lo = lo; v.pres_hi = hi;
    v.hold_busy = hold; v.exp_lat = lat; v.exp_err = err; v.exp_pres = pres;
    v.exp_rom = rom;
    return v;
  endfunction

  // Issue one command, play the device side of the line, check every cycle.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] data,
                         input logic [63:0] rom_in, input int pres_lo, input int pres_hi,
                         input bit hold_busy, input int exp_lat, input bit exp_err,
                         input bit exp_pres, input logic [63:0] exp_rom, input string tag);
    int   rsp_k;
    int   wave_bad;
    int   ready_bad;
    int   hold_bad;
    int   slot;
    int   off;
    int   rel;
    logic exp_low;
    rsp_k = 0; wave_bad = 0; ready_bad = 0; hold_bad = 0;
    @(negedge clk);
    chk({tag, " ready_before"}, {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; bus_in = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= exp_lat + 1; k++) begin
      @(negedge clk);
      if (hold_busy && (k <= exp_lat)) begin
        cmd_valid = 1'b1;
        cmd_op    = (op == 2'b10) ? 2'b01 : 2'b10;
        cmd_data  = ~data;
      end else begin
        cmd_valid = 1'b0;
      end
      slot = (k - 1) / T_SLOT;
      off  = (k - 1) % T_SLOT;
      bus_in = 1'b1;
      if ((op == 2'b00) && (k > T_RSTL)) begin
        rel = k - 1 - T_RSTL;
        if ((rel >= pres_lo) && (rel <= pres_hi)) bus_in = 1'b0;
      end
      if ((op == 2'b10) && (k < exp_lat)) begin
        bus_in = ((off >= 25) && (off <= 35)) ? rom_in[slot] : ~rom_in[slot];
      end
      exp_low = 1'b0;
      if (k < exp_lat) begin
        case (op)
          2'b00:   exp_low = (k <= T_RSTL);
          2'b01:   exp_low = (off < (data[slot] ? T_LOW1 : T_LOW0));
          2'b10:   exp_low = (off < T_LOW1);
          default: exp_low = 1'b0;
        endcase
      end
      if (bus_drive_low !== exp_low) wave_bad++;
      if ((k <= exp_lat) && (cmd_ready !== 1'b0)) ready_bad++;
      if ((rsp_valid === 1'b1) && (rsp_k == 0)) rsp_k = k;
      if ((k < exp_lat) && ((rom_data !== m_rom) || (presence !== m_pres))) hold_bad++;
      if (k == exp_lat) begin
        chk({tag, " rsp_err"}, {63'd0, rsp_err}, {63'd0, exp_err});
        chk({tag, " presence"}, {63'd0, presence}, {63'd0, exp_pres});
        chk({tag, " rom_data"}, rom_data, exp_rom);
      end
      if (k == exp_lat + 1) begin
        chk({tag, " ready_after"}, {63'd0, cmd_ready}, 64'd1);
        chk({tag, " rsp_pulse_end"}, {63'd0, rsp_valid}, 64'd0);
      end
    end
    chk({tag, " latency"}, rsp_k, exp_lat);
    chk({tag, " bus_wave_errs"}, wave_bad, 64'd0);
    chk({tag, " ready_busy_errs"}, ready_bad, 64'd0);
    chk({tag, " result_hold_errs"}, hold_bad, 64'd0);
    m_rom  = exp_rom;
    m_pres = exp_pres;
    cmd_valid = 1'b0;
  endtask

  function automatic int model_lat(input logic [1:0] op);
    case (op)
      2'b00:   return 1 + T_RSTL + T_RSTH;
      2'b01:   return 1 + 8 * T_SLOT;
      2'b10:   return 1 + 64 * T_SLOT;
      default: return 1;
    endcase
  endfunction

  initial begin
    logic [1:0]  r_op;
    logic [7:0]  r_data;
    logic [63:0] r_rom;
    int          r_lo;
    int          r_hi;
    bit          r_hold;
    bit          r_pres;
    logic [63:0] r_exp_rom;
    int          seen;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00; bus_in = 1'b1;
    m_rom = 64'd0; m_pres = 1'b0;

    // Expected columns come from the latency formulas and sample points by hand.
    vecs[0] = mk(2'b00, 8'h00, 64'd0, 60, 200, 1'b0, 961, 1'b0, 1'b1, 64'd0);
    vecs[1] = mk(2'b00, 8'h00, 64'd0, 1000, 0, 1'b0, 961, 1'b0, 1'b0, 64'd0);
    vecs[2] = mk(2'b01, 8'hA5, 64'd0, 0, -1, 1'b0, 489, 1'b0, 1'b0, 64'd0);
    vecs[3] = mk(2'b10, 8'h00, 64'h28FF_1234_5678_9A01, 0, -1, 1'b0, 3905, 1'b0, 1'b0,
                 64'h28FF_1234_5678_9A01);
    vecs[4] = mk(2'b11, 8'h3C, 64'd0, 0, -1, 1'b1, 1, 1'b1, 1'b0, 64'h28FF_1234_5678_9A01);
    vecs[5] = mk(2'b00, 8'h00, 64'd0, 70, 70, 1'b0, 961, 1'b0, 1'b1, 64'h28FF_1234_5678_9A01);
    vecs[6] = mk(2'b01, 8'h00, 64'd0, 0, -1, 1'b1, 489, 1'b0, 1'b1, 64'h28FF_1234_5678_9A01);
    vecs[7] = mk(2'b11, 8'hFF, 64'd0, 0, -1, 1'b0, 1, 1'b1, 1'b1, 64'h28FF_1234_5678_9A01);
    vecs[8] = mk(2'b00, 8'h00, 64'd0, 71, 150, 1'b0, 961, 1'b0, 1'b0, 64'h28FF_1234_5678_9A01);
    vecs[9] = mk(2'b01, 8'hFF, 64'd0, 0, -1, 1'b0, 489, 1'b0, 1'b0, 64'h28FF_1234_5678_9A01);

    repeat (3) @(negedge clk);
    chk("reset bus_drive_low", {63'd0, bus_drive_low}, 64'd0);
    chk("reset rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("reset rsp_err", {63'd0, rsp_err}, 64'd0);
    chk("reset presence", {63'd0, presence}, 64'd0);
    chk("reset rom_data", rom_data, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset cmd_ready", {63'd0, cmd_ready}, 64'd1);

    for (int i = 0; i < 10; i++) begin
      run_cmd(vecs[i].op, vecs[i].data, vecs[i].rom_in, vecs[i].pres_lo, vecs[i].pres_hi,
              vecs[i].hold_busy, vecs[i].exp_lat, vecs[i].exp_err, vecs[i].exp_pres,
              vecs[i].exp_rom, $sformatf("vec%0d", i));
    end

    // Reset in the middle of READ_ROM slot 20 aborts the op silently.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_data = 8'h00; bus_in = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 1 + 20 * T_SLOT + 3; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    chk("abort pre_rst drive", {63'd0, bus_drive_low}, 64'd1);
    rst = 1'b1;
    #1;
    chk("abort bus released", {63'd0, bus_drive_low}, 64'd0);
    chk("abort rom_data", rom_data, 64'd0);
    chk("abort presence", {63'd0, presence}, 64'd0);
    chk("abort rsp_valid", {63'd0, rsp_valid}, 64'd0);
    @(negedge clk);
    rst = 1'b0; bus_in = 1'b1;
    m_rom = 64'd0; m_pres = 1'b0;
    @(posedge clk); #1;
    chk("abort ready_first_edge", {63'd0, cmd_ready}, 64'd1);
    seen = 0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if ((rsp_valid !== 1'b0) || (bus_drive_low !== 1'b0)) seen++;
    end
    chk("abort silent_cycles_bad", seen, 64'd0);
    run_cmd(2'b00, 8'h00, 64'd0, 60, 200, 1'b0, 961, 1'b0, 1'b1, 64'd0, "post_abort_reset");

    // Randomized commands against the slot-arithmetic model.
    for (int r = 0; r < 8; r++) begin
      r_op   = 2'($urandom_range(0, 3));
      r_data = 8'($urandom);
      r_rom  = {32'($urandom), 32'($urandom)};
      r_lo   = $urandom_range(40, 100);
      r_hi   = r_lo + $urandom_range(0, 30);
      r_hold = 1'($urandom_range(0, 1));
      r_pres = (r_op == 2'b00) ? ((r_lo <= T_PRES) && (T_PRES <= r_hi)) : m_pres;
      r_exp_rom = (r_op == 2'b10) ? r_rom : m_rom;
      run_cmd(r_op, r_data, r_rom, r_lo, r_hi, r_hold, model_lat(r_op), (r_op == 2'b11),
              r_pres, r_exp_rom, $sformatf("rand%0d_op%0d", r, r_op));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
